// File: rtl/rx_fifo_buff_if.sv
// Bus between the RX packet assembler / APB register side and the receive FIFO.
// The master drives pushes, pops and error clears; the slave (the FIFO) returns head data and status.
interface rx_fifo_buff_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  logic                    load_buffer;
  logic [DATA_WIDTH-1:0]   packet_data;
  logic                    data_read;
  logic                    clear_errors;
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    data_ready;
  logic                    overrun_error;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    almost_full;

  modport master (
    output load_buffer, packet_data, data_read, clear_errors,
    input  rx_data, data_ready, overrun_error, fifo_count, almost_full
  );

  modport slave (
    input  load_buffer, packet_data, data_read, clear_errors,
    output rx_data, data_ready, overrun_error, fifo_count, almost_full
  );
endinterface

// File: rtl/rx_fifo_buff.sv
// DEPTH-entry show-ahead receive FIFO between the RX packet assembler and the APB register side.
// Tracks fill level, almost-full, and a sticky overrun flag for pushes dropped while full.
module rx_fifo_buff #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  rx_fifo_buff_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overrun;
  logic                  is_empty;
  logic                  is_full;
  logic                  do_push;
  logic                  do_pop;

  // A full FIFO still accepts a push when the same cycle pops, since a slot frees up.
  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(DEPTH));
  assign do_pop   = bus.data_read && !is_empty;
  assign do_push  = bus.load_buffer && (!is_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= bus.packet_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A dropped push wins over a same-cycle clear so the loss is never hidden.
      if (bus.load_buffer && !do_push) begin
        overrun <= 1'b1;
      end else if (bus.clear_errors) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = is_empty ? '0 : mem[rd_ptr];
  assign bus.data_ready    = !is_empty;
  assign bus.overrun_error = overrun;
  assign bus.fifo_count    = count;
  assign bus.almost_full   = (count >= CNT_W'(AF_LEVEL));
endmodule

// File: doc/rx_fifo_buff.md
Name: rx_fifo_buff

Overview:
- Parametrised successor to the single-entry UART receive data buffer.
- Replaces the one-byte holding register with a DEPTH-entry show-ahead FIFO, so the APB side can lag the receiver by several packets before data is lost.
- Sits between the RX packet assembler (load_buffer/packet_data) and the APB slave register interface (data_read/rx_data).
- Adds a fill-level count, an almost-full flag and a sticky overrun error with explicit clear.

Parameters:
- DATA_WIDTH, 8: width of each received packet word.
- DEPTH, 4: number of FIFO entries; power of two, >= 2.
- AF_LEVEL, 3: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- load_buffer  input  1  one-cycle strobe: push packet_data
- packet_data  input  DATA_WIDTH  received word, valid when load_buffer=1
- data_read  input  1  one-cycle strobe: pop head entry
- clear_errors  input  1  clears sticky overrun_error
- rx_data  output  DATA_WIDTH  head-of-FIFO word (show-ahead)
- data_ready  output  1  FIFO non-empty
- overrun_error  output  1  sticky: a push was dropped while full
- fifo_count  output  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH
- almost_full  output  1  fifo_count >= AF_LEVEL

Behaviour:
- Reset (async, n_rst=0):
  - wr_ptr, rd_ptr and fifo_count reset to 0.
  - overrun_error=0, data_ready=0, almost_full=0, rx_data='0.
  - Storage contents need not be cleared.
- Reset mid-operation discards all entries and the error immediately. The first cycle after release behaves as empty.
- Push: load_buffer=1 and (count<DEPTH or data_read pops in the same cycle).
  - Writes packet_data at wr_ptr.
  - wr_ptr advances modulo DEPTH (natural wrap, no extra bit needed for full/empty; fifo_count is the authority).
- Pop: data_read=1 and count>0. rd_ptr advances modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged
  - neither: unchanged
- Latency:
  - Word pushed at edge N appears on rx_data with data_ready=1 after edge N (one cycle; the old LOAD staging state is removed).
  - After a pop at edge N, the next entry appears on rx_data after edge N; data_ready falls after edge N if the FIFO became empty.
- rx_data:
  - Equals the storage entry at rd_ptr when count>0.
  - Forced to '0 when count==0.
  - No bypass: a word pushed into an empty FIFO is not visible in the same cycle.
- data_ready = (fifo_count != 0). almost_full = (fifo_count >= AF_LEVEL). Both are derived from the registered count, so they are glitch-free and timing-aligned.
- Full, load_buffer=1, data_read=0:
  - Word is dropped; storage, pointers and count are unchanged.
  - overrun_error is set after the edge.
- Full, load_buffer=1, data_read=1: pop and push both occur; no overrun; count stays DEPTH.
- Empty, data_read=1: ignored (no pointer move, no underflow). Empty with load and read together: push only; read ignored.
- overrun_error:
  - Set condition has priority over clear_errors in the same cycle.
  - Otherwise clear_errors=1 clears it.
  - Stays set across pops and pushes until cleared or reset.
  - Does not block further pushes once space exists.
- Width rule: fifo_count is $clog2(DEPTH)+1 bits so DEPTH itself is representable.
- No state machine beyond pointer/count registers. The overrun flag is the only control state.

Test Plan (DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3):
- Reset, then push 0xA5 at edge 1 -> after edge 1: rx_data=0xA5, data_ready=1, fifo_count=1. Pop at edge 3 -> after edge 3: data_ready=0, rx_data=0x00, fifo_count=0.
- Push 0x11,0x22,0x33 on consecutive cycles -> almost_full rises after the third push, fifo_count=3. Pop three times -> rx_data sequence 0x11,0x22,0x33 (head always visible before each pop).
- Fill with 0x01..0x04, then push 0x05 with no read -> overrun_error=1, fifo_count=4, drained order 0x01..0x04 (0x05 lost). clear_errors pulse -> overrun_error=0.
- Full FIFO, load 0x99 and data_read in the same cycle -> no overrun, fifo_count stays 4. Draining yields 0x02,0x03,0x04,0x99.
- Empty FIFO, data_read pulses, plus simultaneous load 0x5A and read -> no underflow. fifo_count=1, rx_data=0x5A. Then 10 push/pop pairs spanning pointer wrap -> data order preserved.
- Overrun set and clear_errors asserted in the same cycle -> overrun_error=1. Assert n_rst mid-fill at count=3 -> all outputs immediately zero.
